// File: rtl/sipo_collector_pkg.sv
// Shared widths, derived-size helpers and FSM state types for the serial-in,
// parallel-out collector.
package sipo_pkg;

  localparam int DEF_SIZE_DATA_IN  = 2;
  localparam int DEF_SIZE_DATA_OUT = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } acc_state_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic int calc_depth(input int size_in, input int size_out);
    return size_out / size_in;
  endfunction

  // A one-bit counter is the floor, even for degenerate depths.
  function automatic int calc_cnt_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sipo_collector_if.sv
// Symbol stream in, word stream out.
// Handshake: a word transfers on a rising edge where o_valid=1 and i_ready=1.
// A symbol is taken on a rising edge where i_valid=1 and i_flush=0.
interface sipo_collector_if #(
  parameter int SIZE_DATA_IN  = sipo_pkg::DEF_SIZE_DATA_IN,
  parameter int SIZE_DATA_OUT = sipo_pkg::DEF_SIZE_DATA_OUT
);
  logic                     i_valid;
  logic [SIZE_DATA_IN-1:0]  i_data;
  logic                     i_flush;
  logic                     i_ready;
  logic [SIZE_DATA_OUT-1:0] o_data;
  logic                     o_valid;
  logic                     o_busy;
  logic                     o_overflow;

  modport master (
    output i_valid, i_data, i_flush, i_ready,
    input  o_data, o_valid, o_busy, o_overflow
  );

  modport slave (
    input  i_valid, i_data, i_flush, i_ready,
    output o_data, o_valid, o_busy, o_overflow
  );
endinterface

// File: rtl/sipo_collector_out_buf.sv
// Single-entry valid/ready holding register. A load while full and not being
// drained is dropped and reported with a registered one-cycle pulse.
module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int SIZE_DATA_OUT = DEF_SIZE_DATA_OUT
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_load,
  input  logic [SIZE_DATA_OUT-1:0] i_load_data,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [SIZE_DATA_OUT-1:0] o_data,
  output logic                     o_drop,
  output out_state_e               o_state
);

  out_state_e               state, state_d;
  logic [SIZE_DATA_OUT-1:0] data_q, data_d;
  logic                     drop_q, drop_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= EMPTY;
      data_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state  <= state_d;
      data_q <= data_d;
      drop_q <= drop_d;
    end
  end

  always_comb begin
    state_d = state;
    data_d  = data_q;
    drop_d  = 1'b0;
    case (state)
      EMPTY: begin
        if (i_load) begin
          state_d = FULL;
          data_d  = i_load_data;
        end
      end
      FULL: begin
        if (i_load && i_ready) begin
          data_d = i_load_data;
        end else if (i_load) begin
          drop_d = 1'b1;
        end else if (i_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    o_valid = (state == FULL);
    o_data  = o_valid ? data_q : '0;
    o_drop  = drop_q;
    o_state = state;
  end

endmodule

// File: rtl/sipo_collector.sv
// Reassembles narrow symbols (LSB symbol first) into full words and hands
// them to a single-word output buffer.
module sipo_collector
  import sipo_pkg::*;
#(
  parameter int SIZE_DATA_IN  = DEF_SIZE_DATA_IN,
  parameter int SIZE_DATA_OUT = DEF_SIZE_DATA_OUT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  sipo_collector_if.slave  bus,
  output acc_state_e       dbg_acc_state,
  output out_state_e       dbg_out_state
);

  localparam int DEPTH = calc_depth(SIZE_DATA_IN, SIZE_DATA_OUT);
  localparam int CNT_W = calc_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  if ((SIZE_DATA_OUT % SIZE_DATA_IN) != 0 || DEPTH < 2) begin : g_param_check
    $error("sipo_collector: SIZE_DATA_OUT must be a multiple (>=2x) of SIZE_DATA_IN");
  end

  acc_state_e               acc_state, acc_state_d;
  logic [CNT_W-1:0]         count, count_d;
  logic [SIZE_DATA_OUT-1:0] asm_q, asm_d;
  logic [SIZE_DATA_OUT-1:0] word;
  logic                     word_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_state <= IDLE;
      count     <= '0;
      asm_q     <= '0;
    end else begin
      acc_state <= acc_state_d;
      count     <= count_d;
      asm_q     <= asm_d;
    end
  end

  // word is the assembly register with the current symbol dropped into its slot;
  // flush takes priority over an incoming symbol.
  always_comb begin
    acc_state_d = acc_state;
    count_d     = count;
    asm_d       = asm_q;
    word_done   = 1'b0;
    word        = asm_q;
    word[int'(count)*SIZE_DATA_IN +: SIZE_DATA_IN] = bus.i_data;
    if (bus.i_flush) begin
      acc_state_d = IDLE;
      count_d     = '0;
      asm_d       = '0;
    end else if (bus.i_valid) begin
      if (count == LAST) begin
        word_done   = 1'b1;
        acc_state_d = IDLE;
        count_d     = '0;
        asm_d       = '0;
      end else begin
        acc_state_d = COLLECT;
        count_d     = count + 1'b1;
        asm_d       = word;
      end
    end
  end

  always_comb begin
    bus.o_busy    = (acc_state == COLLECT);
    dbg_acc_state = acc_state;
  end

  sipo_out_buf #(
    .SIZE_DATA_OUT(SIZE_DATA_OUT)
  ) u_out_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (word_done),
    .i_load_data (word),
    .i_ready     (bus.i_ready),
    .o_valid     (bus.o_valid),
    .o_data      (bus.o_data),
    .o_drop      (bus.o_overflow),
    .o_state     (dbg_out_state)
  );

endmodule

// File: tb/tb_sipo_collector.sv
// Directed and randomized bench for sipo_collector against a queue-based
// reference model of symbol reassembly and single-word output holding.
module tb_sipo_collector;
  import sipo_pkg::*;

  localparam int W_IN  = 2;
  localparam int W_OUT = 16;
  localparam int DEPTH = W_OUT / W_IN;

  logic i_clk;
  logic i_rst_n;
  acc_state_e dbg_acc_state;
  out_state_e dbg_out_state;

  sipo_collector_if #(.SIZE_DATA_IN(W_IN), .SIZE_DATA_OUT(W_OUT)) bus ();

  sipo_collector #(
    .SIZE_DATA_IN  (W_IN),
    .SIZE_DATA_OUT (W_OUT)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .bus           (bus),
    .dbg_acc_state (dbg_acc_state),
    .dbg_out_state (dbg_out_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // reference model state
  logic [W_IN-1:0]  sym_q[$];
  logic [W_OUT-1:0] exp_q[$];
  logic             ovf_exp;
  int n_vec;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [W_OUT-1:0] d_exp;
    d_exp = (exp_q.size() != 0) ? exp_q[0] : '0;
    check({tag, ".o_valid"},    32'(bus.o_valid),    32'(exp_q.size() != 0));
    check({tag, ".o_data"},     32'(bus.o_data),     32'(d_exp));
    check({tag, ".o_busy"},     32'(bus.o_busy),     32'(sym_q.size() != 0));
    check({tag, ".o_overflow"}, 32'(bus.o_overflow), 32'(ovf_exp));
  endtask

  function automatic logic [W_OUT-1:0] assemble();
    logic [W_OUT-1:0] w;
    w = '0;
    for (int k = 0; k < DEPTH; k++) w = w | (W_OUT'(sym_q[k]) << (k * W_IN));
    return w;
  endfunction

  // driver: apply one cycle of inputs, advance the model, compare after the edge
  task automatic step(input logic v, input logic [W_IN-1:0] d, input logic fl,
                      input logic rdy, input string tag);
    logic done;
    logic [W_OUT-1:0] w;
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_flush = fl;
    bus.i_ready = rdy;
    @(posedge i_clk);
    done = 1'b0;
    w    = '0;
    if (fl) begin
      sym_q.delete();
    end else if (v) begin
      sym_q.push_back(d);
      if (sym_q.size() == DEPTH) begin
        w    = assemble();
        done = 1'b1;
        sym_q.delete();
      end
    end
    ovf_exp = 1'b0;
    if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
    if (done) begin
      if (exp_q.size() == 0) exp_q.push_back(w);
      else ovf_exp = 1'b1;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic send_word(input logic [W_OUT-1:0] word, input logic rdy,
                           input logic rdy_last, input string tag);
    for (int k = 0; k < DEPTH; k++)
      step(1'b1, word[k*W_IN +: W_IN], 1'b0, (k == DEPTH - 1) ? rdy_last : rdy, tag);
  endtask

  task automatic idle(input logic rdy, input string tag);
    step(1'b0, '0, 1'b0, rdy, tag);
  endtask

  task automatic do_reset(input string tag);
    #1;
    i_rst_n = 1'b0;
    sym_q.delete();
    exp_q.delete();
    ovf_exp = 1'b0;
    #1;
    check({tag, ".o_valid"},    32'(bus.o_valid),    32'(0));
    check({tag, ".o_data"},     32'(bus.o_data),     32'(0));
    check({tag, ".o_busy"},     32'(bus.o_busy),     32'(0));
    check({tag, ".o_overflow"}, 32'(bus.o_overflow), 32'(0));
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
  endtask

  logic [W_OUT-1:0] word_a;

  initial begin
    n_vec   = 0;
    n_fail  = 0;
    ovf_exp = 1'b0;
    word_a  = 16'hA5C3;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    do_reset("reset");
    idle(1'b0, "post_reset");

    // single word, consumer ready
    send_word(word_a, 1'b1, 1'b1, "single");
    check("single.word_const", 32'(bus.o_data), 32'h0000_A5C3);
    idle(1'b1, "single.drain");
    check("single.drained", 32'(bus.o_valid), 32'(0));

    // gaps after symbols 2 and 5
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b1, word_a[k*W_IN +: W_IN], 1'b0, 1'b1, "gap");
      if (k == 1 || k == 4) begin
        idle(1'b1, "gap.hold");
        check("gap.busy_const", 32'(bus.o_busy), 32'(1));
      end
    end
    check("gap.word_const", 32'(bus.o_data), 32'h0000_A5C3);
    idle(1'b1, "gap.drain");

    // backpressure and overflow
    send_word(word_a, 1'b0, 1'b0, "bp.first");
    send_word(16'h1234, 1'b0, 1'b0, "bp.second");
    check("bp.ovf_const", 32'(bus.o_overflow), 32'(1));
    check("bp.held_const", 32'(bus.o_data), 32'h0000_A5C3);
    idle(1'b0, "bp.wait");
    idle(1'b1, "bp.accept");
    check("bp.empty_const", 32'(bus.o_valid), 32'(0));

    // accept and complete on the same edge
    send_word(word_a, 1'b0, 1'b0, "simul.fill");
    send_word(16'hFFFF, 1'b0, 1'b1, "simul.swap");
    check("simul.data_const", 32'(bus.o_data), 32'h0000_FFFF);
    check("simul.ovf_const", 32'(bus.o_overflow), 32'(0));
    idle(1'b1, "simul.drain");

    // flush mid-word, flush beats a concurrent symbol
    for (int k = 0; k < 3; k++) step(1'b1, 2'b11, 1'b0, 1'b1, "flush.partial");
    step(1'b1, 2'b11, 1'b1, 1'b1, "flush.hit");
    send_word(16'h00FF, 1'b1, 1'b1, "flush.word");
    check("flush.word_const", 32'(bus.o_data), 32'h0000_00FF);
    idle(1'b1, "flush.drain");

    // reset mid-word and while holding
    send_word(16'hBEEF, 1'b0, 1'b0, "rst.hold");
    for (int k = 0; k < 4; k++) step(1'b1, 2'b10, 1'b0, 1'b0, "rst.partial");
    do_reset("rst.mid");
    send_word(16'h5555, 1'b1, 1'b1, "rst.word");
    check("rst.word_const", 32'(bus.o_data), 32'h0000_5555);
    idle(1'b1, "rst.drain");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), W_IN'($urandom_range(0, 3)),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_collector.md
# sipo_collector

Serial-in, parallel-out collector that sits directly downstream of the team's parallel-to-serial stage. It consumes that stage's narrow symbol stream (data plus valid) and reassembles full words, least-significant symbol first. It presents each completed word on a valid/ready output port with single-word buffering, so the next word can accumulate while the previous one waits for the consumer.

## Interface
- SIZE_DATA_IN, default 2: serial symbol width in bits.
- SIZE_DATA_OUT, default 16: reassembled word width in bits. Must be an integer multiple of SIZE_DATA_IN, with a ratio of at least 2.
- DEPTH, derived as SIZE_DATA_OUT / SIZE_DATA_IN: symbols per word. Default 8.
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  symbol strobe from the upstream serializer.
- i_data  in  SIZE_DATA_IN  symbol; sampled only when i_valid=1.
- i_flush  in  1  synchronous discard of any partial word.
- i_ready  in  1  downstream accepts o_data this cycle.
- o_data  out  SIZE_DATA_OUT  reassembled word; forced to 0 while o_valid=0.
- o_valid  out  1  o_data holds an unaccepted word.
- o_busy  out  1  partial word in progress (symbol count ≠ 0).
- o_overflow  out  1  one-cycle pulse when a completed word is dropped.

## Operation
- Accumulator: a count of width $clog2(DEPTH) and a SIZE_DATA_OUT-bit assembly register.
  - Symbol k of a word (k = 0..DEPTH-1) lands in bits [k·SIZE_DATA_IN +: SIZE_DATA_IN].
  - The first symbol received occupies the LSBs.
- Accumulator states:
  - IDLE (count=0): a symbol moves it to COLLECT with count=1.
  - COLLECT: each symbol increments count.
  - On symbol DEPTH-1 the word completes, count wraps to 0, and the state returns to IDLE.
- i_valid gaps mid-word are legal. The accumulator holds with no timeout.
- Output holding register states: EMPTY (o_valid=0) and FULL (o_valid=1).
  - EMPTY → FULL on word completion.
  - FULL → EMPTY on i_ready=1 with no simultaneous completion.
  - FULL stays FULL on i_ready=1 with a simultaneous completion; the new word is loaded.
- Overflow: a word completes while FULL and i_ready=0.
  - The new word is dropped and the held word is kept intact.
  - o_overflow pulses for 1 cycle.
  - The accumulator still returns to IDLE.
- i_flush:
  - Clears count to 0 and the assembly register to 0.
  - Does not touch the holding register or o_valid.
  - i_flush=1 together with i_valid=1: flush wins, the symbol is discarded, and no word completes.
- i_ready is ignored while EMPTY.
- Reset values: o_data=0, o_valid=0, o_busy=0, o_overflow=0, count=0, assembly register=0.
- Reset asserted mid-word or while FULL discards everything immediately. No partial state survives.

## Timing
- Latency: last symbol sampled at edge N → o_valid=1 and o_data valid after edge N (visible in cycle N+1).
- Throughput: one symbol per cycle sustained. With i_ready held high, one word is delivered every DEPTH cycles and no overflow occurs.
- Back-to-back words: symbol 0 of the next word can arrive in the cycle right after the completing symbol.
- o_busy is registered: it is 1 from the cycle after the first symbol until the cycle after the completing symbol.
- o_overflow is registered: it asserts in the cycle after the dropping edge.
- o_valid is registered. It drops the cycle after the accepting edge unless a replacement word is loaded on that same edge.
- o_data is combinationally gated with o_valid. There is no other combinational path from input to output.

## Structure
- Shared package sipo_pkg holds:
  - default widths;
  - the DEPTH and count-width derivation (function using $clog2);
  - the state enums (acc_state_e: IDLE/COLLECT; out_state_e: EMPTY/FULL).
- Parameter legality is checked at elaboration: zero remainder and ratio ≥ 2, otherwise $error.
- One natural sub-module, sipo_out_buf: the single-entry valid/ready holding register.
  - Inputs: load, load data, ready.
  - Outputs: valid, data, drop pulse.
- The accumulator and count stay in the top level.

## Test plan
- Single word: symbols 11,00,00,11,01,01,10,10 on consecutive cycles with i_ready=1 → one cycle later o_valid=1, o_data=16'hA5C3. o_valid drops the next cycle and o_busy=0.
- Gapped input: the same 8 symbols with i_valid=0 inserted after symbols 2 and 5 → o_data=16'hA5C3 one cycle after the last symbol. o_busy stays 1 throughout the gaps.
- Backpressure and overflow: two consecutive words 16'hA5C3 then 16'h1234 with i_ready=0 → the first word is held, o_overflow pulses once at completion of the second, and o_data stays 16'hA5C3. Asserting i_ready then yields one transfer and o_valid=0.
- Simultaneous accept and complete: FULL with 16'hA5C3, i_ready=1 on the cycle 16'hFFFF completes → no overflow pulse, o_valid stays 1, o_data=16'hFFFF.
- Flush: 3 symbols, then i_flush=1 together with i_valid=1, then a full word 16'h00FF → o_data=16'h00FF and no stale bits.
- Reset mid-word: reset asserted after 4 symbols, then a full word 16'h5555 → all outputs are 0 during reset and 16'h5555 is reassembled correctly afterwards.
